// File: rtl/sync_fwft_fifo_if.sv
// Producer/consumer bundle for the single-clock FWFT FIFO.
// The FIFO sits on the slave modport; the driver of both sides uses master.
interface sync_fwft_fifo_if #(
    parameter int DataWidth = 64,
    parameter int Deepth    = 8
);
    localparam int CntW = $clog2(Deepth) + 1;

    logic [DataWidth-1:0] wdata;
    logic                 wvalid;
    logic                 wready;
    logic [DataWidth-1:0] rdata;
    logic                 rvalid;
    logic                 rready;
    logic [CntW-1:0]      count;
    logic                 almost_full;
    logic                 almost_empty;

    modport master (
        output wdata, wvalid, rready,
        input  wready, rdata, rvalid, count, almost_full, almost_empty
    );

    modport slave (
        input  wdata, wvalid, rready,
        output wready, rdata, rvalid, count, almost_full, almost_empty
    );
endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO: RAM array behind a registered head.
// Count covers RAM entries plus the head register, so the RAM holds Count-1.
module sync_fwft_fifo #(
    parameter int DataWidth = 64,
    parameter int Deepth    = 8,
    parameter int AFullThr  = 6,
    parameter int AEmptyThr = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    sync_fwft_fifo_if.slave  bus
);
    localparam int PtrW = $clog2(Deepth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(Deepth);

    logic [DataWidth-1:0] mem_q [Deepth];

    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 afull_q, afull_d;
    logic                 aempty_q, aempty_d;

    logic                 push;
    logic                 pop;
    logic                 ram_we;

    assign push = bus.wvalid & (count_q != Full);
    assign pop  = rvalid_q & bus.rready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        ram_we   = 1'b0;

        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            rvalid_d = 1'b0;
        end else begin
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end

            if (!rvalid_q) begin
                if (push) begin
                    rdata_d  = bus.wdata;
                    rvalid_d = 1'b1;
                end
            end else if (pop) begin
                // RAM non-empty: refill head from RAM; otherwise bypass the new word
                if (count_q > CntW'(1)) begin
                    rdata_d  = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                    ram_we   = push;
                end else if (push) begin
                    rdata_d = bus.wdata;
                end else begin
                    rvalid_d = 1'b0;
                end
            end else begin
                ram_we = push;
            end

            if (ram_we) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
        end

        afull_d  = (count_d >= CntW'(AFullThr));
        aempty_d = (count_d <= CntW'(AEmptyThr));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem_q[wr_ptr_q] <= bus.wdata;
        end
    end

    assign bus.wready       = (count_q != Full);
    assign bus.rdata        = rdata_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.count        = count_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;

    a_count_bound: assert property (
        @(posedge clk_i) disable iff (rst_i) count_q <= Full);
    a_no_push_full: assert property (
        @(posedge clk_i) disable iff (rst_i) !(ram_we && count_q == Full));
    a_no_pop_empty: assert property (
        @(posedge clk_i) disable iff (rst_i) !(pop && count_q == '0));
endmodule
